// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: initial hash value, round functions, FSM states.
package sha256_pkg;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int NUM_ROUNDS      = 64;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, DONE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// Sliding 16-word message window; slot 0 is W_t. Load mode shifts in input
// words, expand mode shifts in the next schedule word W_{t+16}.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic        expand_en,
  input  logic [31:0] din,
  output logic [31:0] wt
);

  logic [31:0] w [16];
  logic [31:0] w_next;

  always_comb w_next = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (load_en || expand_en) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= load_en ? din : w_next;
    end
  end

  assign wt = w[0];

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression core, one round per cycle, external K ROM.
//   state  | meaning
//   IDLE   | waiting for word 0; picks IV or chained H as starting point
//   LOAD   | accepting message words 1..15
//   ROUND  | 64 compression rounds, k_idx = t
//   UPDATE | fold working variables into H
//   DONE   | digest_valid pulse
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         first_block,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [31:0]  w_data,
  output logic [5:0]   k_idx,
  input  logic [31:0]  k_val,
  output logic         busy,
  output logic [255:0] digest,
  output logic         digest_valid
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [5:0]  rnd_q;
  logic [31:0] hv [8];
  logic [31:0] wv [8];
  logic        load_en, expand_en;
  logic [31:0] wt, t1, t2;

  sha256_msg_schedule u_sched (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .expand_en (expand_en),
    .din       (w_data),
    .wt        (wt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    w_ready      = 1'b0;
    k_idx        = '0;
    busy         = (state_q != IDLE);
    digest_valid = 1'b0;
    load_en      = 1'b0;
    expand_en    = 1'b0;
    case (state_q)
      IDLE: begin
        w_ready = 1'b1;
        if (w_valid) begin
          load_en = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          load_en = 1'b1;
          if (cnt_q == 4'(WORDS_PER_BLOCK - 1)) state_d = ROUND;
        end
      end
      ROUND: begin
        k_idx     = rnd_q;
        expand_en = 1'b1;
        if (rnd_q == 6'(NUM_ROUNDS - 1)) state_d = UPDATE;
      end
      UPDATE: state_d = DONE;
      DONE: begin
        digest_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    t1 = wv[7] + bsig1(wv[4]) + ch(wv[4], wv[5], wv[6]) + k_val + wt;
    t2 = bsig0(wv[0]) + maj(wv[0], wv[1], wv[2]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      rnd_q <= '0;
      for (int i = 0; i < 8; i++) begin
        hv[i] <= IV[255-32*i -: 32];
        wv[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: if (w_valid) begin
          cnt_q <= 4'd1;
          rnd_q <= '0;
          for (int i = 0; i < 8; i++) begin
            if (first_block) begin
              hv[i] <= IV[255-32*i -: 32];
              wv[i] <= IV[255-32*i -: 32];
            end else begin
              wv[i] <= hv[i];
            end
          end
        end
        // cnt_q wraps to 0 on the 16th word
        LOAD: if (w_valid) cnt_q <= cnt_q + 4'd1;
        ROUND: begin
          rnd_q <= rnd_q + 6'd1;
          wv[0] <= t1 + t2;
          wv[1] <= wv[0];
          wv[2] <= wv[1];
          wv[3] <= wv[2];
          wv[4] <= wv[3] + t1;
          wv[5] <= wv[4];
          wv[6] <= wv[5];
          wv[7] <= wv[6];
        end
        UPDATE: for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wv[i];
        default: ;
      endcase
    end
  end

  assign digest = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};

endmodule

// File: doc/sha256_compress.md
Name: sha256_compress

Overview:
- Iterative SHA-256 compression core and the consumer of the round-constant ROM.
- Drives the 6-bit constant index and reads the 32-bit K_t back combinationally.
- Accepts one 512-bit message block as 16 big-endian words over a valid/ready stream.
- Runs 64 rounds at one round per cycle, folds the result into the chaining state and presents a 256-bit digest.

Parameters:
- None. All widths are fixed by FIPS 180-4: 32-bit word, 64 rounds, 16-word block.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- first_block  in  1  sampled with word 0; 1 = start chaining from IV, 0 = continue from current H
- w_valid  in  1  message word valid
- w_ready  out  1  core can accept a word
- w_data  in  32  message word, W0 first, big-endian
- k_idx  out  6  round-constant index to ROM
- k_val  in  32  K[k_idx], combinational from ROM, same cycle
- busy  out  1  high in every state except IDLE
- digest  out  256  H0..H7, H0 in bits [255:224]
- digest_valid  out  1  one-cycle pulse when digest is updated

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, word count 0, round count 0, k_idx=0, busy=0, digest_valid=0.
  - H0..H7 = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19); digest reflects H, so it equals IV after reset.
  - Reset mid-LOAD or mid-ROUND aborts the block. Partial words are discarded and no digest_valid is produced.
- States: IDLE, LOAD, ROUND, UPDATE, DONE.
- IDLE:
  - w_ready=1.
  - A handshake (w_valid & w_ready) stores word 0 into window slot 15 and moves to LOAD with count=1.
  - On that same edge a..h load from IV if first_block=1, else from H.
  - When first_block=1, H is also loaded with IV on that same edge.
- LOAD:
  - w_ready=1. Each handshake shifts the 16x32 window (slot 0 is oldest).
  - w_valid=0 stalls with no state change; gaps are unlimited.
  - The 16th accepted word moves to ROUND with t=0.
- ROUND, t = 0..63:
  - w_ready=0; k_idx=t.
  - W_t = window[0].
  - T1 = h + Σ1(e) + Ch(e,f,g) + k_val + W_t.
  - T2 = Σ0(a) + Maj(a,b,c).
  - Standard a..h update; all additions are modulo 2^32 with carry out dropped.
  - Window shifts left by one and slot 15 receives σ1(w[14]) + w[9] + σ0(w[1]) + w[0]. Schedule generation is uniform for every t; slot 15 after round 63 is unused.
  - After t=63 go to UPDATE. k_idx never exceeds 63.
- UPDATE:
  - One cycle. Hi <= Hi + working var (mod 2^32). Go to DONE.
- DONE:
  - One cycle. digest_valid=1 and w_ready=0. Return to IDLE.
- Latency: edge accepting word 15 = E0. Rounds occur on E1..E64, UPDATE on E65, digest_valid high during the cycle after E65. Throughput is one block per 66 cycles plus 16 load cycles.
- digest holds H stably between updates and is never cleared except by reset.
- k_idx holds 0 outside ROUND.
- first_block is ignored on words 1..15.
- w_data is ignored when w_valid=0.

Decomposition:
- sha256_pkg:
  - IV constants H0..H7.
  - Functions rotr, Σ0, Σ1, σ0, σ1, Ch, Maj.
  - State enum.
  - Constants WORDS_PER_BLOCK=16 and NUM_ROUNDS=64.
- Sub-module sha256_msg_schedule: the 16-word window with load-shift and expand-shift modes, output W_t.
- The constant ROM stays external and is connected at the top level via k_idx/k_val.

Test Plan:
- "abc" (61626380, words 1..14 = 0, word 15 = 00000018), first_block=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; digest_valid high exactly 66 cycles after the word-15 edge.
- Empty message (80000000, rest 0), first_block=1 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (block 2 with first_block=0) -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; the intermediate digest_valid after block 1 also fires.
- Random w_valid gaps and held invalid w_data during LOAD -> "abc" digest unchanged.
- During ROUND -> k_idx steps 0..63 one per cycle, w_ready=0, busy=1.
- rst pulse at round 30, then "abc" with first_block=1 -> no stray digest_valid, digest=IV after reset, then the correct "abc" digest.
